// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with a counted burst controller.
// Direct ops run in IDLE; SHIFT repeats a latched op for burst_len enabled cycles.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHL   = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_ROL   = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ASR   = 3'b101;
    localparam logic [2:0] M_LOAD  = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bmode;
    logic             is_shift;
    logic             accept;
    logic             zero_len;
    logic             last;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] r;
        r = v;
        unique case (op)
            M_HOLD:  r = v;
            M_SHL:   r = {v[WIDTH-2:0], sl};
            M_SHR:   r = {sr, v[WIDTH-1:1]};
            M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   r = {v[0], v[WIDTH-1:1]};
            M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            M_LOAD:  r = ld;
            M_CLEAR: r = '0;
        endcase
        return r;
    endfunction

    assign is_shift = (mode >= M_SHL) && (mode <= M_ASR);
    assign accept   = (state == IDLE) && start && is_shift;
    assign zero_len = (burst_len == '0);
    assign last     = (state == SHIFT) && enable && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !zero_len) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == SHIFT);
        sout_msb = q[WIDTH-1];
        sout_lsb = q[0];
    end

    // An accepted start never touches q; the first shift is on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            cnt   <= '0;
            bmode <= M_HOLD;
            done  <= 1'b0;
        end else begin
            done <= last || (accept && zero_len);
            if (state == SHIFT) begin
                if (enable) begin
                    q   <= apply_op(bmode, q, sin_l, sin_r, load_data);
                    cnt <= cnt - CNT_W'(1);
                end
            end else if (accept) begin
                if (!zero_len) begin
                    bmode <= mode;
                    cnt   <= burst_len;
                end
            end else if (enable) begin
                q <= apply_op(mode, q, sin_l, sin_r, load_data);
            end
        end
    end
endmodule
